// File: rtl/equiv_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | equiv_scoreboard: in-order gold vs. modified digest comparator with      |
// | saturating counters, first-mismatch capture and an optional skew         |
// | watchdog enabled by the EQUIV_SB_TIMEOUT_EN macro.         Rev 1.0       |
// +--------------------------------------------------------------------------+
module equiv_scoreboard #(
  parameter int DATA_W  = 128,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              gold_valid,
  input  logic [DATA_W-1:0] gold_data,
  input  logic              mod_valid,
  input  logic [DATA_W-1:0] mod_data,
  output logic              cmp_valid,
  output logic              cmp_match,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [DATA_W-1:0] first_mm_gold,
  output logic [DATA_W-1:0] first_mm_mod,
  output logic              first_mm_valid,
  output logic              overflow,
  output logic              timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [OW-1:0]    OCC_ONE  = OW'(1);
  localparam logic [OW-1:0]    OCC_FULL = OW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BAL  = 2'd1,
    SKEW = 2'd2,
    TOUT = 2'd3
  } state_t;

  if (DATA_W < 1 || CNT_W < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1)
  begin : g_param_check
    $error("equiv_scoreboard: illegal parameter set");
  end

  logic [DATA_W-1:0] gold_mem [DEPTH];
  logic [DATA_W-1:0] mod_mem  [DEPTH];

  logic [AW-1:0]     gold_wp_q, gold_wp_d, gold_rp_q, gold_rp_d;
  logic [AW-1:0]     mod_wp_q, mod_wp_d, mod_rp_q, mod_rp_d;
  logic [OW-1:0]     gold_occ_q, gold_occ_d, mod_occ_q, mod_occ_d;
  logic              cmp_valid_q, cmp_valid_d, cmp_match_q, cmp_match_d;
  logic [CNT_W-1:0]  match_cnt_q, match_cnt_d, mismatch_cnt_q, mismatch_cnt_d;
  logic [DATA_W-1:0] first_mm_gold_q, first_mm_gold_d, first_mm_mod_q, first_mm_mod_d;
  logic              first_mm_valid_q, first_mm_valid_d, overflow_q, overflow_d;
  logic              pop, gold_push, mod_push, pair_eq;
  state_t            occ_state, state_q;

  always_comb begin
    pop       = (gold_occ_q != '0) && (mod_occ_q != '0);
    // A full FIFO can still take a word in the cycle it is popped.
    gold_push = gold_valid && ((gold_occ_q != OCC_FULL) || pop);
    mod_push  = mod_valid && ((mod_occ_q != OCC_FULL) || pop);
    pair_eq   = (gold_mem[gold_rp_q] == mod_mem[mod_rp_q]);

    gold_wp_d        = gold_wp_q;
    gold_rp_d        = gold_rp_q;
    mod_wp_d         = mod_wp_q;
    mod_rp_d         = mod_rp_q;
    gold_occ_d       = gold_occ_q;
    mod_occ_d        = mod_occ_q;
    cmp_valid_d      = 1'b0;
    cmp_match_d      = 1'b0;
    match_cnt_d      = match_cnt_q;
    mismatch_cnt_d   = mismatch_cnt_q;
    first_mm_gold_d  = first_mm_gold_q;
    first_mm_mod_d   = first_mm_mod_q;
    first_mm_valid_d = first_mm_valid_q;
    overflow_d       = overflow_q;

    if (clear) begin
      gold_wp_d        = '0;
      gold_rp_d        = '0;
      mod_wp_d         = '0;
      mod_rp_d         = '0;
      gold_occ_d       = '0;
      mod_occ_d        = '0;
      match_cnt_d      = '0;
      mismatch_cnt_d   = '0;
      first_mm_gold_d  = '0;
      first_mm_mod_d   = '0;
      first_mm_valid_d = 1'b0;
      overflow_d       = 1'b0;
    end else begin
      if (gold_push) gold_wp_d = gold_wp_q + PTR_ONE;
      if (mod_push)  mod_wp_d  = mod_wp_q + PTR_ONE;
      if (pop) begin
        gold_rp_d = gold_rp_q + PTR_ONE;
        mod_rp_d  = mod_rp_q + PTR_ONE;
      end
      gold_occ_d = gold_occ_q + (gold_push ? OCC_ONE : '0) - (pop ? OCC_ONE : '0);
      mod_occ_d  = mod_occ_q + (mod_push ? OCC_ONE : '0) - (pop ? OCC_ONE : '0);
      if ((gold_valid && !gold_push) || (mod_valid && !mod_push)) overflow_d = 1'b1;

      cmp_valid_d = pop;
      cmp_match_d = pop && pair_eq;
      if (pop && pair_eq && (match_cnt_q != CNT_MAX)) match_cnt_d = match_cnt_q + CNT_ONE;
      if (pop && !pair_eq) begin
        if (mismatch_cnt_q != CNT_MAX) mismatch_cnt_d = mismatch_cnt_q + CNT_ONE;
        if (!first_mm_valid_q) begin
          first_mm_gold_d  = gold_mem[gold_rp_q];
          first_mm_mod_d   = mod_mem[mod_rp_q];
          first_mm_valid_d = 1'b1;
        end
      end
    end

    if (gold_occ_d == '0 && mod_occ_d == '0)      occ_state = IDLE;
    else if (gold_occ_d != '0 && mod_occ_d != '0) occ_state = BAL;
    else                                          occ_state = SKEW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gold_wp_q        <= '0;
      gold_rp_q        <= '0;
      mod_wp_q         <= '0;
      mod_rp_q         <= '0;
      gold_occ_q       <= '0;
      mod_occ_q        <= '0;
      cmp_valid_q      <= 1'b0;
      cmp_match_q      <= 1'b0;
      match_cnt_q      <= '0;
      mismatch_cnt_q   <= '0;
      first_mm_gold_q  <= '0;
      first_mm_mod_q   <= '0;
      first_mm_valid_q <= 1'b0;
      overflow_q       <= 1'b0;
    end else begin
      gold_wp_q        <= gold_wp_d;
      gold_rp_q        <= gold_rp_d;
      mod_wp_q         <= mod_wp_d;
      mod_rp_q         <= mod_rp_d;
      gold_occ_q       <= gold_occ_d;
      mod_occ_q        <= mod_occ_d;
      cmp_valid_q      <= cmp_valid_d;
      cmp_match_q      <= cmp_match_d;
      match_cnt_q      <= match_cnt_d;
      mismatch_cnt_q   <= mismatch_cnt_d;
      first_mm_gold_q  <= first_mm_gold_d;
      first_mm_mod_q   <= first_mm_mod_d;
      first_mm_valid_q <= first_mm_valid_d;
      overflow_q       <= overflow_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (gold_push && !clear) gold_mem[gold_wp_q] <= gold_data;
    if (mod_push && !clear)  mod_mem[mod_wp_q]   <= mod_data;
  end

`ifdef EQUIV_SB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] SKEW_ONE  = TW'(1);
  localparam logic [TW-1:0] SKEW_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] skew_cnt_q;
  logic          timeout_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
`ifdef EQUIV_SB_TIMEOUT_EN
      skew_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else if (clear) begin
      state_q    <= IDLE;
`ifdef EQUIV_SB_TIMEOUT_EN
      skew_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else if (state_q != TOUT) begin
      state_q    <= occ_state;
`ifdef EQUIV_SB_TIMEOUT_EN
      skew_cnt_q <= '0;
      // Another full cycle of one-sided occupancy; the last one trips the watchdog.
      if (state_q == SKEW && occ_state == SKEW) begin
        if (skew_cnt_q == SKEW_LAST) begin
          state_q   <= TOUT;
          timeout_q <= 1'b1;
        end else begin
          skew_cnt_q <= skew_cnt_q + SKEW_ONE;
        end
      end
`endif
    end
  end

  assign cmp_valid      = cmp_valid_q;
  assign cmp_match      = cmp_match_q;
  assign match_cnt      = match_cnt_q;
  assign mismatch_cnt   = mismatch_cnt_q;
  assign first_mm_gold  = first_mm_gold_q;
  assign first_mm_mod   = first_mm_mod_q;
  assign first_mm_valid = first_mm_valid_q;
  assign overflow       = overflow_q;
`ifdef EQUIV_SB_TIMEOUT_EN
  assign timeout        = timeout_q;
`else
  assign timeout        = 1'b0;
`endif

endmodule

`default_nettype wire
